// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encoding
// and the sequential increment.
package pc_pkg;

  // Increment from one instruction address to the next.
  localparam int unsigned PC_INC = 4;

  // Which source wins the next-PC selection this cycle.
  typedef enum logic [2:0] {
    SrcExc,
    SrcEret,
    SrcRedir,
    SrcHold,
    SrcRet,
    SrcCall,
    SrcSeq
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full silently overwrites the
// oldest entry; a replace on an empty stack acts as a push.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WORD  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] top,
  output logic [CW-1:0]   count
);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [AW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;

  // Next pointer/count and write port; the pointer wraps so full pushes overwrite the oldest.
  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (push || (replace && cnt_q == '0)) begin
      tp_d   = tp_q + 1'b1;
      wr_en  = 1'b1;
      wr_idx = tp_d;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (replace) begin
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (pop && cnt_q != '0) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_idx] <= wdata;
  end

  assign top   = mem_q[tp_q];
  assign count = cnt_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: strict-priority next-PC selection, exception PC,
// and return-address-stack prediction for calls and returns.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     WORD      = 32,
  parameter logic [WORD-1:0] RESET_VEC = '0,
  parameter logic [WORD-1:0] EXC_VEC   = 'h80,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_target,
  input  logic            exc_valid,
  input  logic            eret,
  input  logic            call_valid,
  input  logic [WORD-1:0] call_target,
  input  logic            ret_valid,
  output logic [WORD-1:0] curr,
  output logic [WORD-1:0] next_seq,
  output logic [WORD-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ret_miss,
  output logic            addr_err
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WORD-1:0] curr_q, curr_d, epc_q, epc_d, raw;
  logic            ret_miss_q, ret_miss_d, addr_err_q, addr_err_d;
  logic            chk, push, pop, replace;
  logic [WORD-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  pc_src_e         src;

  assign next_seq = curr_q + WORD'(PC_INC);

  // Pick the winning next-PC source in strict priority order.
  always_comb begin
    src = SrcSeq;
    if (exc_valid)           src = SrcExc;
    else if (eret)           src = SrcEret;
    else if (redirect_valid) src = SrcRedir;
    else if (stall)          src = SrcHold;
    else if (ret_valid)      src = SrcRet;
    else if (call_valid)     src = SrcCall;
  end

  // Target mux, stack control and one-cycle status pulses for the winning source.
  always_comb begin
    raw        = next_seq;
    epc_d      = epc_q;
    push       = 1'b0;
    pop        = 1'b0;
    replace    = 1'b0;
    ret_miss_d = 1'b0;
    chk        = 1'b0;
    unique case (src)
      SrcExc: begin
        raw   = EXC_VEC;
        epc_d = curr_q;
        chk   = 1'b1;
      end
      SrcEret: begin
        raw = epc_q;
        chk = 1'b1;
      end
      SrcRedir: begin
        raw = redirect_target;
        chk = 1'b1;
      end
      SrcHold: raw = curr_q;
      SrcRet: begin
        chk = 1'b1;
        if (call_valid) begin
          // Call and return together: jump to the predicted return and swap in our own link.
          replace = 1'b1;
          if (!ras_empty) raw = ras_top;
        end else if (!ras_empty) begin
          raw = ras_top;
          pop = 1'b1;
        end else begin
          ret_miss_d = 1'b1;
        end
      end
      SrcCall: begin
        raw  = call_target;
        push = 1'b1;
        chk  = 1'b1;
      end
      default: raw = next_seq;
    endcase
    curr_d     = {raw[WORD-1:2], 2'b00};
    addr_err_d = chk & (|raw[1:0]);
  end

  // PC, exception PC and status pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      curr_q     <= {RESET_VEC[WORD-1:2], 2'b00};
      epc_q      <= '0;
      ret_miss_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      curr_q     <= curr_d;
      epc_q      <= epc_d;
      ret_miss_q <= ret_miss_d;
      addr_err_q <= addr_err_d;
    end
  end

  pc_ras #(
    .WORD  (WORD),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .wdata   (next_seq),
    .top     (ras_top),
    .count   (ras_count)
  );

  assign curr      = curr_q;
  assign epc       = epc_q;
  assign ret_miss  = ret_miss_q;
  assign addr_err  = addr_err_q;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

endmodule
